// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter.
// Mode encoding used by the pipe and the combinational core.
package shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t SH_LSR = 2'b00;
  localparam mode_t SH_ASR = 2'b01;
  localparam mode_t SH_SHL = 2'b10;
  localparam mode_t SH_ROR = 2'b11;

endpackage

// File: rtl/shift_core.sv
// Combinational shift datapath between the S1 and S2 registers.
// amt is already reduced modulo DATAWIDTH; sat flags an oversized amount.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  localparam int SHW = $clog2(DATAWIDTH)
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [SHW-1:0]       amt,
  input  mode_t                mode,
  input  logic                 sat,
  output logic [DATAWIDTH-1:0] result
);

  localparam logic [SHW:0] DWS = (SHW+1)'(DATAWIDTH);

  logic [DATAWIDTH-1:0]        lsr_v;
  logic signed [DATAWIDTH-1:0] asr_v;
  logic [DATAWIDTH-1:0]        shl_v;
  logic [DATAWIDTH-1:0]        ror_v;
  logic [DATAWIDTH-1:0]        fill_v;

  assign lsr_v  = a >> amt;
  assign asr_v  = $signed(a) >>> amt;
  assign shl_v  = a << amt;
  // A left shift by the full width yields 0, so amt=0 rotates to a.
  assign ror_v  = (a >> amt) | (a << (DWS - {1'b0, amt}));
  assign fill_v = {DATAWIDTH{a[DATAWIDTH-1]}};

  always_comb begin
    result = '0;
    unique case (mode)
      SH_LSR: result = sat ? '0 : lsr_v;
      SH_ASR: result = sat ? fill_v : asr_v;
      SH_SHL: result = sat ? '0 : shl_v;
      SH_ROR: result = ror_v;
    endcase
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage stallable shifter: S1 holds the decoded command,
// S2 holds the result; valid/ready with full backpressure.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  input  mode_t                mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] d
);

  localparam int SHW = $clog2(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] DW_VAL =
    DATAWIDTH'(DATAWIDTH);

  logic                 adv1;
  logic                 adv2;
  logic [SHW-1:0]       in_amt;
  logic                 in_sat;

  logic                 s1_valid;
  logic [DATAWIDTH-1:0] s1_a;
  logic [SHW-1:0]       s1_amt;
  mode_t                s1_mode;
  logic                 s1_sat;

  logic                 s2_valid;
  logic [DATAWIDTH-1:0] s2_d;
  logic [DATAWIDTH-1:0] core_d;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // The true modulo serves ROR and, when not saturated,
  // equals sh_amt for the other modes.
  assign in_amt = SHW'(sh_amt % DW_VAL);
  assign in_sat = sh_amt >= DW_VAL;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_amt   <= '0;
      s1_mode  <= SH_LSR;
      s1_sat   <= 1'b0;
      s2_valid <= 1'b0;
      s2_d     <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= a;
          s1_amt  <= in_amt;
          s1_mode <= mode;
          s1_sat  <= in_sat;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          s2_d <= core_d;
      end
    end
  end

  shift_core #(
    .DATAWIDTH(DATAWIDTH)
  ) u_core (
    .a      (s1_a),
    .amt    (s1_amt),
    .mode   (s1_mode),
    .sat    (s1_sat),
    .result (core_d)
  );

  assign out_valid = s2_valid;
  assign d         = s2_d;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and random checks of shift_unit_pipe against an
// arithmetic reference model with an in-order scoreboard.
module tb_shift_unit_pipe;

  logic       Clk;
  logic       Rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] sh_amt;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int cur_run  = 0;
  int max_run  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  shift_unit_pipe #(.DATAWIDTH(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .sh_amt    (sh_amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(int av, int sh, int m);
    int v, p, q, n;
    case (m)
      0: q = (sh >= 8) ? 0 : av / (1 << sh);
      1: begin
        v = (av >= 128) ? av - 256 : av;
        if (sh >= 8) q = (v < 0) ? 255 : 0;
        else begin
          p = 1 << sh;
          q = (v >= 0) ? v / p : -((-v + p - 1) / p);
          q = (q + 256) % 256;
        end
      end
      2: q = (sh >= 8) ? 0 : (av * (1 << sh)) % 256;
      default: begin
        n = sh % 8;
        q = (av / (1 << n) + av * (1 << (8 - n))) % 256;
      end
    endcase
    return 8'(q);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst) begin
      exp_q.delete();
      cur_run = 0;
    end else begin
      cur_run = out_valid ? cur_run + 1 : 0;
      if (cur_run > max_run) max_run = cur_run;
      if (out_valid && out_ready) begin
        chk("unexpected_result", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("result_order", d, mon_e);
          pops++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(a, sh_amt, mode));
    end
  end

  task automatic present(input logic [7:0] av,
                         input logic [7:0] sh,
                         input logic [1:0] m);
    in_valid = 1'b1;
    a        = av;
    sh_amt   = sh;
    mode     = m;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 1);
  endtask

  task automatic send(input logic [7:0] av,
                      input logic [7:0] sh,
                      input logic [1:0] m);
    @(posedge Clk);
    #1;
    present(av, sh, m);
    @(negedge Clk);
    wait_accept();
  endtask

  task automatic idle();
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_single(input logic [7:0] av,
                              input logic [7:0] sh,
                              input logic [1:0] m,
                              input logic [7:0] expv,
                              input string tag);
    send(av, sh, m);
    idle();
    @(negedge Clk);
    chk({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge Clk);
    chk({tag, "_lat2_valid"}, out_valid, 1);
    chk(tag, d, expv);
  endtask

  logic [7:0] va [13] = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4,
                          8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4,
                          8'hB4, 8'hB4, 8'h74};
  logic [7:0] vs [13] = '{8'd2, 8'd2, 8'd3, 8'd4, 8'd0,
                          8'd0, 8'd0, 8'd0, 8'd9, 8'd9,
                          8'd9, 8'd9, 8'd200};
  logic [1:0] vm [13] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                          2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
                          2'd2, 2'd3, 2'd1};
  logic [7:0] ve [13] = '{8'h2D, 8'hED, 8'hA0, 8'h4B, 8'hB4,
                          8'hB4, 8'hB4, 8'hB4, 8'h00, 8'hFF,
                          8'h00, 8'h5A, 8'h00};

  initial begin
    logic [7:0] ra, rs, e1;
    logic [1:0] rm;
    int p0;

    Rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hB4;
    sh_amt    = 8'd0;
    mode      = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge Clk);
    chk("rst_input_ignored", out_valid, 0);

    for (int i = 0; i < 13; i++)
      check_single(va[i], vs[i], vm[i], ve[i],
                   $sformatf("vec%0d", i));

    // Backpressure: fill both stages, then stall the output.
    @(negedge Clk);
    p0 = pops;
    out_ready = 1'b0;
    ra = 8'($urandom_range(0, 255));
    rs = 8'($urandom_range(0, 7));
    rm = 2'($urandom_range(0, 3));
    e1 = model(ra, rs, rm);
    send(ra, rs, rm);
    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 9)),
         2'($urandom_range(0, 3)));
    @(posedge Clk);
    #1;
    present(8'($urandom_range(0, 255)),
            8'($urandom_range(0, 9)), 2'($urandom_range(0, 3)));
    repeat (5) begin
      @(negedge Clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_d", d, e1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_rise", in_ready, 1);
    wait_accept();
    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 9)),
         2'($urandom_range(0, 3)));
    idle();
    repeat (6) @(negedge Clk);
    chk("bp_count", pops - p0, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Streaming throughput with random commands.
    p0 = pops;
    max_run = 0;
    for (int i = 0; i < 10; i++) begin
      rs = ($urandom_range(0, 3) == 0) ?
           8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      send(8'($urandom_range(0, 255)), rs,
           2'($urandom_range(0, 3)));
    end
    idle();
    repeat (6) @(negedge Clk);
    chk("tp_run", max_run, 10);
    chk("tp_count", pops - p0, 10);
    chk("tp_queue_empty", exp_q.size(), 0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    send(8'($urandom_range(0, 255)), 8'd1, 2'd0);
    send(8'($urandom_range(0, 255)), 8'd2, 2'd2);
    idle();
    @(negedge Clk);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    p0 = pops;
    out_ready = 1'b1;
    ra = 8'($urandom_range(0, 255));
    check_single(ra, 8'd3, 2'd3, model(ra, 3, 3), "post_rst");
    repeat (4) @(negedge Clk);
    chk("post_rst_count", pops - p0, 1);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
